key_decoder: RTL and testbench
==============================

# key_decoder

Converts the PS/2 scan-code byte stream into the one-hot `key[3:0]` direction word consumed by the car controller. It sits between the PS/2 byte receiver and the car controller in the `pclk` domain. It decodes set-2 make/break/extended sequences and tracks which direction keys are held. It outputs exactly one direction, or none, following a most-recently-pressed rule.

## Interface
- `TIMEOUT`, default 200000: cycles of `pclk` without a byte after which a partial prefix sequence is abandoned. Must be ≥ 2.
- `pclk`  in  1  pixel clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  scan-code byte from the PS/2 receiver; valid only while `rx_valid` = 1.
- `rx_valid`  in  1  single-cycle strobe, one per received byte; no backpressure.
- `key`  out  4  direction to the car controller: UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000, none = 4'b0000. It is never multi-hot.

## Operation
- Codes:
  - Arrows are extended: UP E0 75, DOWN E0 72, LEFT E0 6B, RIGHT E0 74.
  - Break of an arrow = E0 F0 xx.
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - Any other byte: treated as a non-extended make (see Configuration); stay IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay EXT.
    - Arrow code → press that arrow, → IDLE.
    - Any other byte → IDLE, no effect.
  - BRK: any byte → non-extended release (see Configuration), → IDLE.
  - EXT_BRK: arrow code → release that arrow, → IDLE; any other byte → IDLE, no effect.
- Held state: `held[7:0]`, with bits 0-3 for the arrows and bits 4-7 for the WASD keys. A direction is active if either of its sources is held.
- `recent[1:0]` holds the direction of the latest make code. A typematic repeat of a make code also sets `recent`.
- Output selection, evaluated on the next-state values:
  - If `recent`'s direction is active → one-hot of `recent`.
  - Else if any direction is active → the highest priority one, with priority UP > DOWN > LEFT > RIGHT. `recent` is reloaded with that direction.
  - Else → 4'b0000.
- Timeout:
  - A 24-bit counter clears on every `rx_valid`.
  - It increments each cycle while the FSM is not IDLE and saturates.
  - When it reaches `TIMEOUT-1` the FSM returns to IDLE. `held` is unchanged.
- Releasing a key that is not held is a no-op. Pressing a key that is already held only updates `recent`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `held` = 0.
  - `recent` = UP.
  - Counter = 0.
  - `key` = 4'b0000.
- `key` is registered. It reflects the final byte of a sequence on the same `pclk` edge that samples that byte with `rx_valid` = 1, so latency = 1 cycle from strobe to output.
- `key` does not change on prefix bytes (E0, F0).
- Back-to-back strobes on consecutive cycles are fully supported; each byte is consumed in its own cycle.
- A timeout and an `rx_valid` in the same cycle: the byte wins. It is parsed in the current state and the counter clears.
- `rst` mid-sequence discards the partial sequence and all held keys. `key` = 0 on the next cycle.

## Configuration
- `KEY_DECODER_WASD_EN`
  - Defined: non-extended codes are mapped as W 1D → UP, S 1B → DOWN, A 1C → LEFT, D 23 → RIGHT. Make and break of these codes set and clear `held[7:4]`.
  - Undefined: non-extended makes and breaks are ignored. `held[7:4]` is tied to 0.
  - Arrow behaviour is identical in both builds.

## Test plan
- Reset, then E0 75 → `key` = 0001 one cycle after the 75 strobe, and `key` stays 0000 after the E0 strobe.
- Hold UP (E0 75), then E0 74 → `key` = 1000. Then E0 F0 74 → `key` = 0001, the fallback to the still-held UP.
- Hold LEFT and DOWN, with LEFT last; E0 F0 6B → `key` = 0010. Then E0 F0 72 → `key` = 0000.
- With `TIMEOUT` = 8: send E0, wait 10 cycles, then send 75 → no press, `key` = 0000, because the FSM returned to IDLE. Sending 75 again after E0 within 5 cycles → `key` = 0001.
- With `KEY_DECODER_WASD_EN`: send 1D, then E0 75, then F0 1D → `key` stays 0001 because the UP arrow is still held. Without the macro, 1D alone → `key` = 0000.
- Assert `rst` for 1 cycle after E0 F0 (before the code byte) while RIGHT is held → `key` = 0000. A following byte 74 alone has no effect.

Source files
------------

// File: rtl/key_decoder.sv
// PS/2 set-2 scan-code decoder producing a one-hot direction word, most-recently-pressed wins.
// Optional macro KEY_DECODER_WASD_EN maps the non-extended W/S/A/D codes onto the same directions.
module key_decoder #(
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] key
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       held_q, held_d;
    logic [1:0]       recent_q, recent_d;
    logic [3:0]       key_q, key_d;
    logic [2:0]       arw;
    logic [3:0]       active;

    // {valid, direction} for an extended arrow code
    function automatic logic [2:0] arrow_code(input logic [7:0] b);
        case (b)
            8'h75:   return 3'b100;
            8'h72:   return 3'b101;
            8'h6B:   return 3'b110;
            8'h74:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

`ifdef KEY_DECODER_WASD_EN
    logic [2:0] ws;

    function automatic logic [2:0] wasd_code(input logic [7:0] b);
        case (b)
            8'h1D:   return 3'b100;
            8'h1B:   return 3'b101;
            8'h1C:   return 3'b110;
            8'h23:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        recent_d = recent_q;
        key_d    = 4'b0000;
        arw      = arrow_code(rx_data);
`ifdef KEY_DECODER_WASD_EN
        ws       = wasd_code(rx_data);
`endif

        if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else begin
`ifdef KEY_DECODER_WASD_EN
                        if (ws[2]) begin
                            held_d[{1'b1, ws[1:0]}] = 1'b1;
                            recent_d                = ws[1:0];
                        end
`endif
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        state_d = S_IDLE;
                        if (arw[2]) begin
                            held_d[{1'b0, arw[1:0]}] = 1'b1;
                            recent_d                 = arw[1:0];
                        end
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
`ifdef KEY_DECODER_WASD_EN
                    if (ws[2]) held_d[{1'b1, ws[1:0]}] = 1'b0;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    if (arw[2]) held_d[{1'b0, arw[1:0]}] = 1'b0;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            // abandon a stale prefix; a byte arriving in the same cycle takes precedence above
            if (cnt_q >= CNT_LAST) state_d = S_IDLE;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end

`ifndef KEY_DECODER_WASD_EN
        held_d[7:4] = 4'b0000;
`endif

        // most-recent direction if still held, else fixed priority UP > DOWN > LEFT > RIGHT
        active = held_d[3:0] | held_d[7:4];
        if (active[recent_d]) begin
            key_d = 4'b0001 << recent_d;
        end else if (active != 4'b0000) begin
            if (active[0])      recent_d = 2'd0;
            else if (active[1]) recent_d = 2'd1;
            else if (active[2]) recent_d = 2'd2;
            else                recent_d = 2'd3;
            key_d = 4'b0001 << recent_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            held_q   <= '0;
            recent_q <= 2'd0;
            key_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            recent_q <= recent_d;
            key_q    <= key_d;
        end
    end

    assign key = key_q;

endmodule

// File: tb/tb_key_decoder.sv
// Scoreboard bench for key_decoder: expected key word queued per byte, checked one edge later.
module tb_key_decoder;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] key;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [3:0]  exp_q[$];

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_UP   = 4'b0001;
    localparam logic [3:0] K_DN   = 4'b0010;
    localparam logic [3:0] K_LT   = 4'b0100;
    localparam logic [3:0] K_RT   = 4'b1000;

    key_decoder #(.TIMEOUT(8)) dut (
        .pclk    (pclk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .key     (key)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: key=%b expected=%b", tag, got, exp);
        end
    endtask

    // drive one byte, queue its expected key, compare after the sampling edge
    task automatic send(input string tag, input logic [7:0] b, input logic [3:0] exp);
        logic [3:0] e;
        @(negedge pclk);
        rx_data  = b;
        rx_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge pclk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, key, 4'bxxxx);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, key, e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge pclk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (n - 1) @(negedge pclk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge pclk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge pclk);
        #1;
        check_eq(tag, key, K_NONE);
        @(negedge pclk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset");

        // basic UP press, prefix leaves key unchanged
        send("up_e0", 8'hE0, K_NONE);
        send("up_75", 8'h75, K_UP);
        idle(2);
        check_eq("up_hold", key, K_UP);

        // RIGHT overrides, release falls back to held UP
        send("rt_e0", 8'hE0, K_UP);
        send("rt_74", 8'h74, K_RT);
        send("rtb_e0", 8'hE0, K_RT);
        send("rtb_f0", 8'hF0, K_RT);
        send("rtb_74", 8'h74, K_UP);
        send("upb_e0", 8'hE0, K_UP);
        send("upb_f0", 8'hF0, K_UP);
        send("upb_75", 8'h75, K_NONE);
        idle(3);

        // DOWN then LEFT; release LEFT -> DOWN, release DOWN -> none
        send("dn_e0", 8'hE0, K_NONE);
        send("dn_72", 8'h72, K_DN);
        send("lt_e0", 8'hE0, K_DN);
        send("lt_6b", 8'h6B, K_LT);
        send("ltb_e0", 8'hE0, K_LT);
        send("ltb_f0", 8'hF0, K_LT);
        send("ltb_6b", 8'h6B, K_DN);
        send("dnb_e0", 8'hE0, K_DN);
        send("dnb_f0", 8'hF0, K_DN);
        send("dnb_72", 8'h72, K_NONE);
        idle(2);

        // typematic repeat of UP re-selects it over a later RIGHT; double E0 stays extended
        send("tp_e0a", 8'hE0, K_NONE);
        send("tp_75a", 8'h75, K_UP);
        send("tp_e0b", 8'hE0, K_UP);
        send("tp_74", 8'h74, K_RT);
        send("tp_e0c", 8'hE0, K_RT);
        send("tp_e0d", 8'hE0, K_RT);
        send("tp_75b", 8'h75, K_UP);
        send("tp_rb0", 8'hE0, K_UP);
        send("tp_rb1", 8'hF0, K_UP);
        send("tp_rb2", 8'h74, K_UP);
        send("tp_ub0", 8'hE0, K_UP);
        send("tp_ub1", 8'hF0, K_UP);
        send("tp_ub2", 8'h75, K_NONE);
        idle(2);

        // prefix abandoned after timeout, honoured when byte is prompt
        send("to_e0", 8'hE0, K_NONE);
        idle(10);
        send("to_75", 8'h75, K_NONE);
        send("ok_e0", 8'hE0, K_NONE);
        idle(3);
        send("ok_75", 8'h75, K_UP);
        send("ok_b0", 8'hE0, K_UP);
        send("ok_b1", 8'hF0, K_UP);
        send("ok_b2", 8'h75, K_NONE);
        idle(2);

`ifdef KEY_DECODER_WASD_EN
        send("w_1d", 8'h1D, K_UP);
        send("w_e0", 8'hE0, K_UP);
        send("w_75", 8'h75, K_UP);
        send("w_f0", 8'hF0, K_UP);
        send("w_b1d", 8'h1D, K_UP);
        send("w_ub0", 8'hE0, K_UP);
        send("w_ub1", 8'hF0, K_UP);
        send("w_ub2", 8'h75, K_NONE);
        send("d_23", 8'h23, K_RT);
        send("d_f0", 8'hF0, K_RT);
        send("d_b23", 8'h23, K_NONE);
`else
        send("w_1d", 8'h1D, K_NONE);
        send("w_f0", 8'hF0, K_NONE);
        send("w_b1d", 8'h1D, K_NONE);
`endif
        idle(2);

        // reset mid-sequence drops held RIGHT and the partial break
        send("rs_e0", 8'hE0, K_NONE);
        send("rs_74", 8'h74, K_RT);
        send("rs_e0b", 8'hE0, K_RT);
        send("rs_f0", 8'hF0, K_RT);
        do_reset("rs_mid");
        send("rs_74b", 8'h74, K_NONE);
        idle(2);
        check_eq("rs_end", key, K_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
